cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory port between the I-cache and D-cache miss engines behind the pipelined datapath.
//  Grants one whole line transaction at a time. Latches the winner's address, write flag and write data, and drives them downstream.
//  Returns the response only to the owner. Data side has priority, bounded by an anti-starvation limit for the instruction side.
// PARAMETERS
//  ADDR_WIDTH    16   byte address width of both cache-side and pmem-side ports
//  LINE_WIDTH    128  cache line width in bits (read and write data)
//  STARVE_LIMIT  3    consecutive contended D grants allowed before I is forced to win; range 1..15
// PORTS
//  clk             in   1           system clock; all state updates on rising edge
//  reset           in   1           synchronous, active-high reset
//  i_pmem_read     in   1           I-cache line-fill request (level, held until i_pmem_resp)
//  i_pmem_address  in   ADDR_WIDTH  I-cache line address
//  i_pmem_rdata    out  LINE_WIDTH  line read data to I-cache
//  i_pmem_resp     out  1           one-cycle completion pulse to I-cache
//  d_pmem_read     in   1           D-cache line-fill request (level)
//  d_pmem_write    in   1           D-cache write-back request (level); never asserted with d_pmem_read
//  d_pmem_address  in   ADDR_WIDTH  D-cache line address
//  d_pmem_wdata    in   LINE_WIDTH  D-cache write-back data
//  d_pmem_rdata    out  LINE_WIDTH  line read data to D-cache
//  d_pmem_resp     out  1           one-cycle completion pulse to D-cache
//  pmem_read       out  1           downstream read strobe (level)
//  pmem_write      out  1           downstream write strobe (level)
//  pmem_address    out  ADDR_WIDTH  downstream address (registered)
//  pmem_wdata      out  LINE_WIDTH  downstream write data (registered)
//  pmem_rdata      in   LINE_WIDTH  downstream read data, valid with pmem_resp
//  pmem_resp       in   1           downstream completion pulse
// BEHAVIOUR
//  FSM states: IDLE, GRANT_I, GRANT_D (arb_state_t).
//  Decision in IDLE:
//   - D requests only -> GRANT_D. I requests only -> GRANT_I. Neither -> stay in IDLE.
//   - Both request -> GRANT_D, unless streak == STARVE_LIMIT, in which case GRANT_I.
//  On the grant edge:
//   - Latch pmem_address, pmem_wdata and the read/write flag from the winner. The I side is always a read.
//   - pmem_read/pmem_write assert from the next cycle. Latency is 1 cycle from request seen in IDLE to downstream strobe.
//  In GRANT_x:
//   - Hold the strobes and latched fields until pmem_resp.
//   - Requester inputs are ignored. Withdrawal or address change mid-grant does not affect the transaction.
//  When pmem_resp arrives:
//   - Same cycle: owner's *_resp = 1 (combinational). Non-owner resp = 0.
//   - Next edge: go to IDLE and drop the strobes. Every transaction is followed by one IDLE cycle, which lets the requester deassert.
//  pmem_resp in IDLE is ignored (never forwarded).
//  i_pmem_rdata and d_pmem_rdata = pmem_rdata at all times. Only resp qualifies them.
//  Streak counter (4 bits):
//   - +1 on a D grant while i_pmem_read is high. Saturates at STARVE_LIMIT.
//   - Cleared on any I grant, or on a D grant with I idle.
//  Reset values: state IDLE, streak 0. pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0. pmem_address and pmem_wdata are 0.
//  Reset mid-grant aborts the grant. A downstream resp arriving after reset is dropped per the IDLE rule.
//  d_pmem_read && d_pmem_write both high is illegal. Treat it as a write, and flag it with an assertion in simulation.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//   - Adds outputs i_grant_cnt[31:0], d_grant_cnt[31:0] and conflict_cnt[31:0].
//   - Each increments on the grant edge. conflict_cnt increments when both sides requested.
//   - Counters wrap at 2^32 and are cleared by reset.
//  ARB_PERF_CNT_EN undefined: the ports and logic are absent. Arbitration is identical.
// STRUCTURE
//  lc3b_types package gets:
//   - typedef arb_state_t (IDLE, GRANT_I, GRANT_D)
//   - typedef lc3b_line (LINE_WIDTH-bit line)
//   - localparam ARB_STREAK_W = 4
//  Sub-module arb_req_latch: registered address, wdata and rw flag with load enable; loaded on the grant edge.
//  The FSM, streak counter and response steering stay in cache_arbiter.
// TESTING
//  - Reset, then idle: all strobes and resp are 0. pmem_resp pulse in IDLE -> no i/d resp.
//  - I only, addr 0x1230:
//    - cycle+1: pmem_read=1, pmem_address=0x1230.
//    - pmem_resp after 5 cycles -> i_pmem_resp=1 that cycle, d_pmem_resp=0. One IDLE cycle follows.
//  - Same-cycle I read 0x0040 and D write 0x8000, wdata=128'hA5..A5:
//    - GRANT_D first: pmem_write=1, pmem_wdata=A5..A5.
//    - After resp and one IDLE cycle, GRANT_I with addr 0x0040.
//  - STARVE_LIMIT=3, both request continuously: grant order D,D,D,I,D,D,D,I. Streak returns to 0 after each I.
//  - D grant 0x2000 active, D changes address to 0x3000 and drops its request: pmem_address stays 0x2000 until resp.
//  - reset asserted in GRANT_I before resp: next cycle IDLE, strobes 0. A late pmem_resp produces no i_pmem_resp.
//    With ARB_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the cache-to-pmem arbiter
package lc3b_types;
  localparam int LINE_W       = 128;
  localparam int ARB_STREAK_W = 4;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  typedef logic [LINE_W-1:0] lc3b_line;
endpackage

// File: rtl/cache_arbiter_req_latch.sv
// rtl/cache_arbiter_req_latch.sv - winner's address, write data and rw flag held for one transaction
module arb_req_latch
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = LINE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [LINE_WIDTH-1:0] wdata_in,
  input  logic                  write_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LINE_WIDTH-1:0] wdata,
  output logic                  write
);
  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      wdata <= '0;
      write <= 1'b0;
    end else if (load) begin
      addr  <= addr_in;
      wdata <= wdata_in;
      write <= write_in;
    end
  end
endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I/D cache miss arbiter onto one pmem port; ARB_PERF_CNT_EN adds grant counters
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]           i_grant_cnt,
  output logic [31:0]           d_grant_cnt,
  output logic [31:0]           conflict_cnt,
`endif
  input  logic                  pmem_resp
);
  localparam logic [ARB_STREAK_W-1:0] LIMIT = ARB_STREAK_W'(STARVE_LIMIT);

  arb_state_t              state;
  logic [ARB_STREAK_W-1:0] streak;
  logic                    active;
  logic                    latched_write;
  logic                    d_req, contended, pick_d, pick_i, grant;

  assign d_req     = d_pmem_read | d_pmem_write;
  assign contended = i_pmem_read & d_req;
  // D wins every contest except when I has already lost LIMIT in a row
  assign pick_d    = d_req & ~(contended & (streak == LIMIT));
  assign pick_i    = i_pmem_read & ~pick_d;
  assign grant     = (state == IDLE) & (pick_d | pick_i);

  arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH)) u_latch (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .addr_in  (pick_d ? d_pmem_address : i_pmem_address),
    .wdata_in (pick_d ? d_pmem_wdata : '0),
    .write_in (pick_d & d_pmem_write),
    .addr     (pmem_address),
    .wdata    (pmem_wdata),
    .write    (latched_write)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
      active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state  <= GRANT_D;
            active <= 1'b1;
            if (!contended)           streak <= '0;
            else if (streak != LIMIT) streak <= streak + 1'b1;
          end else if (pick_i) begin
            state  <= GRANT_I;
            active <= 1'b1;
            streak <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (pmem_resp) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = active & ~latched_write;
  assign pmem_write   = active & latched_write;
  assign i_pmem_resp  = (state == GRANT_I) & pmem_resp;
  assign d_pmem_resp  = (state == GRANT_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else if (grant) begin
      if (pick_d) d_grant_cnt <= d_grant_cnt + 32'd1;
      else        i_grant_cnt <= i_grant_cnt + 32'd1;
      if (contended) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

  a_no_read_and_write: assert property (@(posedge clk) disable iff (reset)
    !(d_pmem_read && d_pmem_write));
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized and directed check of cache_arbiter against a transaction-level model
module tb_cache_arbiter;
  localparam int LIMIT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read, d_pmem_read, d_pmem_write, pmem_resp;
  logic [15:0]  i_pmem_address, d_pmem_address;
  logic [127:0] d_pmem_wdata, pmem_rdata;
  logic [127:0] i_pmem_rdata, d_pmem_rdata, pmem_wdata;
  logic         i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]  i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
`ifdef ARB_PERF_CNT_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: who owns the port (0 none, 1 I, 2 D) and what that transaction carries
  bit           m_valid = 0;
  int           m_owner;
  bit           m_write;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  int           m_lost;
  int unsigned  m_icnt, m_dcnt, m_ccnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (!m_valid) return;
    check("pmem_read",    pmem_read,    (m_owner != 0) && !m_write);
    check("pmem_write",   pmem_write,   (m_owner != 0) && m_write);
    check("pmem_address", pmem_address, m_addr);
    if (m_owner == 2 && m_write) check("pmem_wdata", pmem_wdata, m_wdata);
    check("i_pmem_resp",  i_pmem_resp,  (m_owner == 1) && pmem_resp);
    check("d_pmem_resp",  d_pmem_resp,  (m_owner == 2) && pmem_resp);
    check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
`ifdef ARB_PERF_CNT_EN
    check("i_grant_cnt",  i_grant_cnt,  m_icnt);
    check("d_grant_cnt",  d_grant_cnt,  m_dcnt);
    check("conflict_cnt", conflict_cnt, m_ccnt);
`endif
  endtask

  task automatic model_step();
    bit dq, cont;
    if (reset) begin
      m_valid = 1; m_owner = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      m_lost = 0; m_icnt = 0; m_dcnt = 0; m_ccnt = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) m_owner = 0;
    end else begin
      dq   = d_pmem_read || d_pmem_write;
      cont = i_pmem_read && dq;
      if (cont) m_ccnt++;
      if (dq && !(cont && m_lost >= LIMIT)) begin
        m_owner = 2; m_write = d_pmem_write; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        m_lost  = cont ? ((m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1) : 0;
        m_dcnt++;
      end else if (i_pmem_read) begin
        m_owner = 1; m_write = 0; m_addr = i_pmem_address; m_wdata = '0;
        m_lost  = 0;
        m_icnt++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  string order;

  initial begin
    reset = 1; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0; pmem_rdata = '0;
    cycle(); cycle();
    reset = 0;
    cycle();
    check("idle pmem_read", pmem_read, 1'b0);
    check("idle pmem_write", pmem_write, 1'b0);
    pmem_resp = 1; #1;
    check("idle resp i", i_pmem_resp, 1'b0);
    check("idle resp d", d_pmem_resp, 1'b0);
    cycle(); pmem_resp = 0;

    i_pmem_read = 1; i_pmem_address = 16'h1230;
    cycle();
    check("i only strobe", pmem_read, 1'b1);
    check("i only addr", pmem_address, 16'h1230);
    repeat (4) cycle();
    pmem_resp = 1; pmem_rdata = {4{32'hCAFE_0001}}; #1;
    check("i only resp", i_pmem_resp, 1'b1);
    check("i only no d resp", d_pmem_resp, 1'b0);
    check("i only rdata", i_pmem_rdata, {4{32'hCAFE_0001}});
    cycle(); pmem_resp = 0; i_pmem_read = 0;
    check("post-txn idle", pmem_read, 1'b0);
    cycle();

    i_pmem_read = 1; i_pmem_address = 16'h0040;
    d_pmem_write = 1; d_pmem_address = 16'h8000; d_pmem_wdata = {16{8'hA5}};
    cycle();
    check("both d first write", pmem_write, 1'b1);
    check("both d wdata", pmem_wdata, {16{8'hA5}});
    check("both d addr", pmem_address, 16'h8000);
    cycle();
    pmem_resp = 1; #1;
    check("both d resp", d_pmem_resp, 1'b1);
    cycle(); pmem_resp = 0; d_pmem_write = 0;
    check("both gap", pmem_read | pmem_write, 1'b0);
    cycle();
    check("both then i addr", pmem_address, 16'h0040);
    check("both then i read", pmem_read, 1'b1);
    pmem_resp = 1; cycle(); pmem_resp = 0; i_pmem_read = 0;
    cycle();

    i_pmem_read = 1; i_pmem_address = 16'h0100;
    d_pmem_read = 1; d_pmem_address = 16'h0200;
    order = "";
    for (int k = 0; k < 8; k++) begin
      cycle();
      order = {order, (pmem_address == 16'h0200) ? "D" : "I"};
      pmem_resp = 1; cycle(); pmem_resp = 0;
    end
    n_checks++;
    if (order != "DDDIDDDI") begin
      n_err++;
      $display("FAIL starve order: got %s expected DDDIDDDI", order);
    end
    i_pmem_read = 0; d_pmem_read = 0;
    cycle();

    d_pmem_read = 1; d_pmem_address = 16'h2000;
    cycle();
    check("hold addr start", pmem_address, 16'h2000);
    d_pmem_address = 16'h3000; d_pmem_read = 0;
    repeat (3) cycle();
    check("hold addr mid", pmem_address, 16'h2000);
    check("hold strobe mid", pmem_read, 1'b1);
    pmem_resp = 1; #1;
    check("hold resp", d_pmem_resp, 1'b1);
    cycle(); pmem_resp = 0;
    cycle();

    i_pmem_read = 1; i_pmem_address = 16'h0ABC;
    cycle();
    check("abort granted", pmem_read, 1'b1);
    reset = 1; cycle(); reset = 0; i_pmem_read = 0;
    check("abort strobe", pmem_read, 1'b0);
    check("abort addr", pmem_address, 16'h0000);
`ifdef ARB_PERF_CNT_EN
    check("abort i cnt", i_grant_cnt, 32'd0);
    check("abort d cnt", d_grant_cnt, 32'd0);
    check("abort c cnt", conflict_cnt, 32'd0);
`endif
    pmem_resp = 1; #1;
    check("late resp dropped", i_pmem_resp, 1'b0);
    cycle(); pmem_resp = 0;

    for (int n = 0; n < 3000; n++) begin
      int op;
      reset          = ($urandom_range(0, 99) == 0);
      i_pmem_read    = $urandom_range(0, 1);
      i_pmem_address = 16'($urandom);
      op             = $urandom_range(0, 2);
      d_pmem_read    = (op == 1);
      d_pmem_write   = (op == 2);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp      = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
